// File: rtl/aes_ushr_sequencer.sv
// Command sequencer for the AES 4x32-bit universal shift-register state buffer.
// Emits per-word mode selects, per-byte enables and the serial feedback select.
//
// state | meaning
// IDLE  | waiting for a command; datapath holds
// LOAD  | parallel load of all 16 bytes
// SR1-3 | ShiftRows passes, rows 1-3 / 2-3 / 3 rotate left one word
// ISR1-3| InvShiftRows passes, same rows rotate right one word
// SIN   | serial stream-in of four words
// SOUT  | non-destructive serial stream-out of four words
// ERR   | one-cycle error report for an illegal code
module aes_ushr_sequencer #(
    parameter int unsigned CMD_W        = 3,
    parameter bit          BACK_TO_BACK = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             cmd_valid_i,
    input  logic [CMD_W-1:0] cmd_code_i,
    output logic             cmd_ready_o,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [1:0]       ushr_mode0_o,
    output logic [1:0]       ushr_mode1_o,
    output logic [1:0]       ushr_mode2_o,
    output logic [1:0]       ushr_mode3_o,
    output logic [15:0]      control_s_o,
    output logic             feedback_en_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o
);

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD, S_SR1, S_SR2, S_SR3,
        S_ISR1, S_ISR2, S_ISR3, S_SIN, S_SOUT, S_ERR
    } state_e;

    localparam logic [1:0] M_HOLD  = 2'd0;
    localparam logic [1:0] M_RIGHT = 2'd1;
    localparam logic [1:0] M_LEFT  = 2'd2;
    localparam logic [1:0] M_LOAD  = 2'd3;

    state_e      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [1:0]  mode;
    logic [15:0] ctrl;
    logic        fb, done, err, in_rdy, out_vld, cmd_rdy;

    function automatic state_e first_state(input logic [CMD_W-1:0] code);
        state_e s;
        if      (code == CMD_W'(0)) s = S_IDLE;
        else if (code == CMD_W'(1)) s = S_LOAD;
        else if (code == CMD_W'(2)) s = S_SR1;
        else if (code == CMD_W'(3)) s = S_ISR1;
        else if (code == CMD_W'(4)) s = S_SIN;
        else if (code == CMD_W'(5)) s = S_SOUT;
        else                        s = S_ERR;
        return s;
    endfunction

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode    = M_HOLD;
        ctrl    = 16'h0000;
        fb      = 1'b0;
        done    = 1'b0;
        err     = 1'b0;
        in_rdy  = 1'b0;
        out_vld = 1'b0;
        case (state_q)
            S_IDLE: ;
            S_LOAD: begin
                mode = M_LOAD;
                ctrl = 16'hFFFF;
                done = 1'b1;
            end
            // Byte masks enable rows 1-3, then 2-3, then 3: row r moves r words.
            S_SR1:  begin mode = M_LEFT;  fb = 1'b1; ctrl = 16'hEEEE; state_d = S_SR2;  end
            S_SR2:  begin mode = M_LEFT;  fb = 1'b1; ctrl = 16'hCCCC; state_d = S_SR3;  end
            S_SR3:  begin mode = M_LEFT;  fb = 1'b1; ctrl = 16'h8888; done = 1'b1;     end
            S_ISR1: begin mode = M_RIGHT; fb = 1'b1; ctrl = 16'hEEEE; state_d = S_ISR2; end
            S_ISR2: begin mode = M_RIGHT; fb = 1'b1; ctrl = 16'hCCCC; state_d = S_ISR3; end
            S_ISR3: begin mode = M_RIGHT; fb = 1'b1; ctrl = 16'h8888; done = 1'b1;     end
            S_SIN: begin
                mode   = M_LEFT;
                in_rdy = 1'b1;
                if (in_valid_i) begin
                    ctrl  = 16'hFFFF;
                    cnt_d = cnt_q + 2'd1;
                    done  = (cnt_q == 2'd3);
                end
            end
            S_SOUT: begin
                mode    = M_LEFT;
                fb      = 1'b1;
                out_vld = 1'b1;
                if (out_ready_i) begin
                    ctrl  = 16'hFFFF;
                    cnt_d = cnt_q + 2'd1;
                    done  = (cnt_q == 2'd3);
                end
            end
            S_ERR: begin
                done = 1'b1;
                err  = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
        if (done) state_d = S_IDLE;
        cmd_rdy = (state_q == S_IDLE) || (BACK_TO_BACK && done);
        if (cmd_valid_i && cmd_rdy) state_d = first_state(cmd_code_i);
    end

    assign ushr_mode0_o  = mode;
    assign ushr_mode1_o  = mode;
    assign ushr_mode2_o  = mode;
    assign ushr_mode3_o  = mode;
    assign control_s_o   = ctrl;
    assign feedback_en_o = fb;
    assign done_o        = done;
    assign err_o         = err;
    assign in_ready_o    = in_rdy;
    assign out_valid_o   = out_vld;
    assign cmd_ready_o   = cmd_rdy;
    assign busy_o        = (state_q != S_IDLE);

endmodule
